shift_decode_stage: RTL and testbench
=====================================

SHIFT_DECODE_STAGE -- requirements
Module: shift_decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered requests (power of two, 2..8).
REQ-002 SHALL have parameter WIDTH, default 16, data width carried to the shifter arrays.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 In_Valid  input  1  upstream request valid.
REQ-006 In_Ready  output  1  stage can accept; high when buffer not full.
REQ-007 In_Op  input  2  00 SLL, 01 SRA, 10 ROR, 11 reserved.
REQ-008 In_Data  input  WIDTH  operand.
REQ-009 In_Amount  input  4  shift amount 0..15.
REQ-010 Out_Valid  output  1  head entry valid.
REQ-011 Out_Ready  input  1  downstream shifter accepts head entry.
REQ-012 Out_Op  output  2  opcode of head entry.
REQ-013 Out_Data  output  WIDTH  operand of head entry.
REQ-014 Base3_0, Base3_1, Base3_2  output  2 each  base-3 digits of amount, weights 1, 3, 9.
REQ-015 Out_Error  output  1  head entry carried reserved opcode.

Function
REQ-016 Transfer in SHALL occur when In_Valid && In_Ready; transfer out when Out_Valid && Out_Ready.
REQ-017 Conversion SHALL be done at enqueue; stored digits satisfy Amount = D0 + 3*D1 + 9*D2, each digit 0..2, never 3 (e.g. 15 -> D2=1, D1=2, D0=0).
REQ-018 Reserved opcode SHALL store digits 0,0,0, Out_Op=11, Out_Error=1; Out_Error=0 otherwise.
REQ-019 Latency SHALL be one cycle: an entry accepted into an empty buffer at edge N shows Out_Valid=1 after edge N.
REQ-020 Buffer SHALL be FIFO-ordered with wrap-around read/write pointers and an occupancy count 0..DEPTH.
REQ-021 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged; accepted when full only if dequeue in same cycle is NOT assumed (In_Ready depends on occupancy only, no combinational path Out_Ready -> In_Ready).
REQ-022 Empty: Out_Valid=0; outputs Out_Op/Out_Data/Base3_x/Out_Error hold last-dequeued values (don't-care to consumer).
REQ-023 Out_* fields SHALL stay stable while Out_Valid=1 and Out_Ready=0.
REQ-024 Sustained throughput SHALL be one request per cycle when Out_Ready held high.

Reset
REQ-025 On Rst=1 at a clock edge: pointers and occupancy 0, Out_Valid=0, In_Ready=1, Base3_x=0, Out_Op=0, Out_Data=0, Out_Error=0.
REQ-026 Rst mid-operation SHALL discard all buffered entries; a same-cycle In_Valid SHALL NOT be accepted.
REQ-027 Reset SHALL take priority over every other update.

Configuration
REQ-028 Macro SHIFT_DECODE_STATS_EN defined: adds output Stat_Count (16 bits), counting accepted requests, saturating at 0xFFFF, cleared by Rst, plus Stat_Errors (8 bits) counting reserved opcodes, saturating.
REQ-029 Macro undefined: no counters, no Stat_* ports; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold opcode constants (OP_SLL, OP_SRA, OP_ROR, OP_RSV) and the entry struct typedef (op, data, three digits, error).
REQ-031 Amount-to-base-3 conversion SHALL be a combinational sub-module amount_to_base3 (4-bit in, three 2-bit digits out), reusable by other shifter front-ends.

Verification
REQ-032 After reset, ROR, Data=0x8001, Amount=15, Out_Ready=1 -> next cycle Out_Valid=1, Base3_2=1, Base3_1=2, Base3_0=0, Out_Data=0x8001.
REQ-033 All 16 amounts enqueued back-to-back, Out_Ready=1 -> 16 consecutive outputs, digits reconstruct 0..15 in order, no digit equals 3.
REQ-034 Out_Ready=0, enqueue DEPTH entries -> In_Ready=0 after DEPTH-th accept; raise Out_Ready -> entries emerge in order, In_Ready returns 1 next cycle.
REQ-035 In_Op=11, Amount=7 -> Out_Error=1, digits 0,0,0, Out_Op=11.
REQ-036 Buffer holding 2 entries, Rst=1 with In_Valid=1 -> after edge Out_Valid=0, In_Ready=1, nothing later emitted.
REQ-037 With SHIFT_DECODE_STATS_EN, 70000 accepts -> Stat_Count=0xFFFF.

Source files
------------

// File: rtl/shift_decode_stage_pkg.sv
// Shared opcode encodings and the buffered entry layout for shifter front-ends.
package shift_decode_stage_pkg;

  // Widest operand any front-end may carry; narrower stages zero-extend into it.
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [MAX_DATA_W-1:0] data;
    logic [1:0]            d2;
    logic [1:0]            d1;
    logic [1:0]            d0;
    logic                  error;
  } entry_t;

endpackage

// File: rtl/shift_decode_stage_base3.sv
// Combinational 4-bit amount to base-3 digits (weights 1, 3, 9); digits never exceed 2.
module amount_to_base3 (
  input  logic [3:0] amount,
  output logic [1:0] d0,
  output logic [1:0] d1,
  output logic [1:0] d2
);

  logic [3:0] r9;

  always_comb begin
    d2 = 2'd0;
    d1 = 2'd0;
    d0 = 2'd0;
    r9 = amount;
    if (amount >= 4'd9) begin
      d2 = 2'd1;
      r9 = amount - 4'd9;
    end
    // r9 is 0..8 here, so each remainder below fits in two bits.
    if (r9 >= 4'd6) begin
      d1 = 2'd2;
      d0 = 2'(r9 - 4'd6);
    end else if (r9 >= 4'd3) begin
      d1 = 2'd1;
      d0 = 2'(r9 - 4'd3);
    end else begin
      d0 = r9[1:0];
    end
  end

endmodule

// File: rtl/shift_decode_stage.sv
// Shift request buffer: converts the amount to base-3 digits at enqueue and holds a FIFO of entries.
// Optional request/error counters when SHIFT_DECODE_STATS_EN is defined.
module shift_decode_stage
  import shift_decode_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       In_Op,
  input  logic [WIDTH-1:0] In_Data,
  input  logic [3:0]       In_Amount,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [1:0]       Out_Op,
  output logic [WIDTH-1:0] Out_Data,
  output logic [1:0]       Base3_0,
  output logic [1:0]       Base3_1,
  output logic [1:0]       Base3_2,
  output logic             Out_Error
`ifdef SHIFT_DECODE_STATS_EN
  ,
  output logic [15:0]      Stat_Count,
  output logic [7:0]       Stat_Errors
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop, rsv;
  logic [1:0]         dig0, dig1, dig2;
  entry_t             new_entry;

  logic [1:0]         last_op;
  logic [WIDTH-1:0]   last_data;
  logic [1:0]         last_d0, last_d1, last_d2;
  logic               last_error;

  amount_to_base3 u_base3 (
    .amount (In_Amount),
    .d0     (dig0),
    .d1     (dig1),
    .d2     (dig2)
  );

  assign In_Ready  = (count != CNT_W'(DEPTH));
  assign Out_Valid = (count != '0);
  assign push      = In_Valid && In_Ready;
  assign pop       = Out_Valid && Out_Ready;
  assign rsv       = (In_Op == OP_RSV);

  always_comb begin
    new_entry       = '0;
    new_entry.op    = op_e'(In_Op);
    new_entry.data  = MAX_DATA_W'(In_Data);
    new_entry.d0    = rsv ? 2'd0 : dig0;
    new_entry.d1    = rsv ? 2'd0 : dig1;
    new_entry.d2    = rsv ? 2'd0 : dig2;
    new_entry.error = rsv;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_op    <= '0;
      last_data  <= '0;
      last_d0    <= '0;
      last_d1    <= '0;
      last_d2    <= '0;
      last_error <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        last_op    <= mem[rd_ptr].op;
        last_data  <= mem[rd_ptr].data[WIDTH-1:0];
        last_d0    <= mem[rd_ptr].d0;
        last_d1    <= mem[rd_ptr].d1;
        last_d2    <= mem[rd_ptr].d2;
        last_error <= mem[rd_ptr].error;
      end
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // The head slot is never the write target while occupied, so it stays stable under backpressure.
  always_comb begin
    if (Out_Valid) begin
      Out_Op    = mem[rd_ptr].op;
      Out_Data  = mem[rd_ptr].data[WIDTH-1:0];
      Base3_0   = mem[rd_ptr].d0;
      Base3_1   = mem[rd_ptr].d1;
      Base3_2   = mem[rd_ptr].d2;
      Out_Error = mem[rd_ptr].error;
    end else begin
      Out_Op    = last_op;
      Out_Data  = last_data;
      Base3_0   = last_d0;
      Base3_1   = last_d1;
      Base3_2   = last_d2;
      Out_Error = last_error;
    end
  end

`ifdef SHIFT_DECODE_STATS_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Stat_Count  <= '0;
      Stat_Errors <= '0;
    end else if (push) begin
      if (Stat_Count != '1)
        Stat_Count <= Stat_Count + 16'd1;
      if (rsv && Stat_Errors != '1)
        Stat_Errors <= Stat_Errors + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_decode_stage.sv
// Directed bench for shift_decode_stage (DEPTH=2, WIDTH=16); counter checks when SHIFT_DECODE_STATS_EN is defined.
module tb_shift_decode_stage;

  logic        Clk = 1'b0;
  logic        Rst, In_Valid, In_Ready, Out_Valid, Out_Ready, Out_Error;
  logic [1:0]  In_Op, Out_Op, Base3_0, Base3_1, Base3_2;
  logic [15:0] In_Data, Out_Data;
  logic [3:0]  In_Amount;
`ifdef SHIFT_DECODE_STATS_EN
  logic [15:0] Stat_Count;
  logic [7:0]  Stat_Errors;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 Clk = ~Clk;

  shift_decode_stage #(.DEPTH(2), .WIDTH(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Op     (In_Op),
    .In_Data   (In_Data),
    .In_Amount (In_Amount),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Op    (Out_Op),
    .Out_Data  (Out_Data),
    .Base3_0   (Base3_0),
    .Base3_1   (Base3_1),
    .Base3_2   (Base3_2),
    .Out_Error (Out_Error)
`ifdef SHIFT_DECODE_STATS_EN
    ,
    .Stat_Count  (Stat_Count),
    .Stat_Errors (Stat_Errors)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so registered state and head outputs are sampled mid-cycle.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
    In_Valid  = v;
    In_Op     = op;
    In_Data   = d;
    In_Amount = amt;
  endtask

  initial begin
    Rst = 1'b1;
    Out_Ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    step();
    step();
    Rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(Out_Valid), 32'd0);
    check("rst_ready", 32'(In_Ready), 32'd1);
    check("rst_digits", {26'd0, Base3_2, Base3_1, Base3_0}, 32'd0);
    check("rst_op", 32'(Out_Op), 32'd0);
    check("rst_data", 32'(Out_Data), 32'd0);
    check("rst_err", 32'(Out_Error), 32'd0);

    // ROR 0x8001 by 15: 15 = 0 + 3*2 + 9*1
    Out_Ready = 1'b1;
    drive(1'b1, 2'b10, 16'h8001, 4'd15);
    step();
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    check("ror_valid", 32'(Out_Valid), 32'd1);
    check("ror_d2", 32'(Base3_2), 32'd1);
    check("ror_d1", 32'(Base3_1), 32'd2);
    check("ror_d0", 32'(Base3_0), 32'd0);
    check("ror_data", 32'(Out_Data), 32'h8001);
    check("ror_op", 32'(Out_Op), 32'd2);
    check("ror_err", 32'(Out_Error), 32'd0);
    step();
    check("ror_drained", 32'(Out_Valid), 32'd0);
    check("ror_hold_data", 32'(Out_Data), 32'h8001);

    // All amounts back to back at full throughput
    for (int unsigned i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, 16'(i + 32'h100), 4'(i));
      step();
      check("seq_valid", 32'(Out_Valid), 32'd1);
      check("seq_ready", 32'(In_Ready), 32'd1);
      check("seq_digits", {26'd0, Base3_2, Base3_1, Base3_0},
            {26'd0, 2'(i / 9), 2'((i % 9) / 3), 2'(i % 3)});
      check("seq_data", 32'(Out_Data), i + 32'h100);
    end
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    step();
    check("seq_empty", 32'(Out_Valid), 32'd0);

    // Fill under backpressure, stall, then drain; a push while full must be refused
    Out_Ready = 1'b0;
    drive(1'b1, 2'b01, 16'h00A0, 4'd4);
    check("full_ready0", 32'(In_Ready), 32'd1);
    step();
    check("full_ready1", 32'(In_Ready), 32'd1);
    drive(1'b1, 2'b01, 16'h00A1, 4'd5);
    step();
    check("full_ready2", 32'(In_Ready), 32'd0);
    check("full_head", 32'(Out_Data), 32'h00A0);
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    step();
    check("stall_data", 32'(Out_Data), 32'h00A0);
    check("stall_digits", {26'd0, Base3_2, Base3_1, Base3_0}, {26'd0, 2'd0, 2'd1, 2'd1});
    check("stall_op", 32'(Out_Op), 32'd1);
    drive(1'b1, 2'b00, 16'h00BB, 4'd1);
    Out_Ready = 1'b1;
    step();
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    check("drain_ready", 32'(In_Ready), 32'd1);
    check("drain_head", 32'(Out_Data), 32'h00A1);
    check("drain_digits", {26'd0, Base3_2, Base3_1, Base3_0}, {26'd0, 2'd0, 2'd1, 2'd2});
    step();
    check("drain_empty", 32'(Out_Valid), 32'd0);
    check("drain_hold", 32'(Out_Data), 32'h00A1);

    // Reserved opcode
    drive(1'b1, 2'b11, 16'h1234, 4'd7);
    step();
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    check("rsv_err", 32'(Out_Error), 32'd1);
    check("rsv_digits", {26'd0, Base3_2, Base3_1, Base3_0}, 32'd0);
    check("rsv_op", 32'(Out_Op), 32'd3);
    step();
    check("rsv_empty", 32'(Out_Valid), 32'd0);

    // Mid-operation reset with a concurrent request
    Out_Ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0C01, 4'd2);
    step();
    drive(1'b1, 2'b00, 16'h0C02, 4'd3);
    step();
    check("pre_rst_full", 32'(In_Ready), 32'd0);
    Rst = 1'b1;
    drive(1'b1, 2'b00, 16'h0C03, 4'd6);
    step();
    Rst = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    check("mrst_valid", 32'(Out_Valid), 32'd0);
    check("mrst_ready", 32'(In_Ready), 32'd1);
    check("mrst_data", 32'(Out_Data), 32'd0);
    Out_Ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("mrst_nothing", 32'(Out_Valid), 32'd0);
    end

`ifdef SHIFT_DECODE_STATS_EN
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("stat_rst", 32'(Stat_Count), 32'd0);
    Out_Ready = 1'b1;
    for (int unsigned i = 0; i < 70000; i++) begin
      drive(1'b1, (i < 300) ? 2'b11 : 2'b00, 16'(i), 4'(i));
      step();
    end
    drive(1'b0, 2'b00, 16'h0000, 4'd0);
    check("stat_count_sat", 32'(Stat_Count), 32'h0000FFFF);
    check("stat_err_sat", 32'(Stat_Errors), 32'h000000FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
